// File: rtl/pll_lock_rst_seq_if.sv
// Signal bundle between the HDMI PLL reset sequencer and its surroundings:
// PLL control/status plus the downstream reset and health indicators.
interface pll_lock_rst_seq_if;
  logic       restart;
  logic       pll_lock;
  logic       pll_rst;
  logic       hdmi_rst;
  logic       locked_ok;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  // master: the sequencer itself
  modport master (
    input  restart,
    input  pll_lock,
    output pll_rst,
    output hdmi_rst,
    output locked_ok,
    output fault,
    output retry_cnt,
    output lock_loss_cnt
  );

  // slave: the PLL wrapper / system controller observing the sequencer
  modport slave (
    output restart,
    output pll_lock,
    input  pll_rst,
    input  hdmi_rst,
    input  locked_ok,
    input  fault,
    input  retry_cnt,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// HDMI PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock and
// only then releases hdmi_rst; retries on timeout and latches a fault.
module pll_lock_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 17
) (
  input  logic                clkin1,
  input  logic                rst,
  pll_lock_rst_seq_if.master  pll
);

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

  state_t           state_reg;
  logic [CNT_W-1:0] timer_reg;
  logic [CNT_W-1:0] timer_inc;
  logic [1:0]       retry_reg;
  logic [7:0]       loss_reg;
  logic             lock_meta_reg;
  logic             lock_s_reg;
  // {pll_rst, hdmi_rst, locked_ok, fault}, loaded together with the state
  logic [3:0]       ctl_reg;

  function automatic logic [3:0] ctl_of(input state_t s);
    case (s)
      RST_PLL:   ctl_of = 4'b1100;
      WAIT_LOCK: ctl_of = 4'b0100;
      STABLE:    ctl_of = 4'b0100;
      RUN:       ctl_of = 4'b0010;
      FAULT:     ctl_of = 4'b1101;
      default:   ctl_of = 4'b1100;
    endcase
  endfunction

  assign timer_inc = (timer_reg == {CNT_W{1'b1}}) ? timer_reg : timer_reg + 1'b1;

  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_reg     <= RST_PLL;
      timer_reg     <= '0;
      ctl_reg       <= ctl_of(RST_PLL);
      retry_reg     <= '0;
      loss_reg      <= '0;
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll.pll_lock;
      lock_s_reg    <= lock_meta_reg;
      if (pll.restart) begin
        state_reg <= RST_PLL;
        timer_reg <= '0;
        retry_reg <= '0;
        ctl_reg   <= ctl_of(RST_PLL);
      end else begin
        case (state_reg)
          RST_PLL: begin
            if (timer_reg == RST_LAST) begin
              state_reg <= WAIT_LOCK;
              timer_reg <= '0;
              ctl_reg   <= ctl_of(WAIT_LOCK);
            end else begin
              timer_reg <= timer_inc;
            end
          end
          WAIT_LOCK: begin
            // a lock arriving on the timeout cycle still counts
            if (lock_s_reg) begin
              state_reg <= STABLE;
              timer_reg <= '0;
              ctl_reg   <= ctl_of(STABLE);
            end else if (timer_reg == TIMEOUT_LAST) begin
              if (retry_reg == RETRY_LIMIT) begin
                state_reg <= FAULT;
                ctl_reg   <= ctl_of(FAULT);
              end else begin
                retry_reg <= retry_reg + 1'b1;
                state_reg <= RST_PLL;
                timer_reg <= '0;
                ctl_reg   <= ctl_of(RST_PLL);
              end
            end else begin
              timer_reg <= timer_inc;
            end
          end
          STABLE: begin
            if (!lock_s_reg) begin
              state_reg <= WAIT_LOCK;
              timer_reg <= '0;
              ctl_reg   <= ctl_of(WAIT_LOCK);
            end else if (timer_reg == STABLE_LAST) begin
              state_reg <= RUN;
              timer_reg <= '0;
              ctl_reg   <= ctl_of(RUN);
            end else begin
              timer_reg <= timer_inc;
            end
          end
          RUN: begin
            if (!lock_s_reg) begin
              if (loss_reg != 8'hFF) begin
                loss_reg <= loss_reg + 1'b1;
              end
              retry_reg <= '0;
              state_reg <= RST_PLL;
              timer_reg <= '0;
              ctl_reg   <= ctl_of(RST_PLL);
            end
          end
          FAULT: begin
            state_reg <= FAULT;
          end
          default: begin
            state_reg <= RST_PLL;
            timer_reg <= '0;
            ctl_reg   <= ctl_of(RST_PLL);
          end
        endcase
      end
    end
  end

  assign pll.pll_rst       = ctl_reg[3];
  assign pll.hdmi_rst      = ctl_reg[2];
  assign pll.locked_ok     = ctl_reg[1];
  assign pll.fault         = ctl_reg[0];
  assign pll.retry_cnt     = retry_reg;
  assign pll.lock_loss_cnt = loss_reg;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Scoreboard bench for pll_lock_rst_seq: a phase/duration reference model
// predicts every output change; a monitor compares each observed change.
module tb_pll_lock_rst_seq;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  typedef struct {
    int          cyc;
    logic [13:0] vec;
  } exp_t;

  logic clk_tb = 1'b0;
  logic rst    = 1'b1;
  always #10 clk_tb = ~clk_tb;

  pll_lock_rst_seq_if pll_if ();

  pll_lock_rst_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (17)
  ) dut (
    .clkin1(clk_tb),
    .rst   (rst),
    .pll   (pll_if.master)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   started  = 0;
  exp_t exp_q[$];

  // reference model: phase, cycles spent in phase, counters, lock history
  int          m_phase = PH_RST;
  int          m_n     = 0;
  int          m_retry = 0;
  int          m_loss  = 0;
  bit          m_s1    = 0;
  bit          m_s2    = 0;
  bit          m_first = 1;
  logic [13:0] m_prev  = '0;
  bit          lock_v  = 0;

  function automatic logic [13:0] m_vec();
    logic [1:0] r;
    logic [7:0] l;
    r = 2'(m_retry);
    l = 8'(m_loss);
    return {(m_phase == PH_RST || m_phase == PH_FAULT), (m_phase != PH_RUN),
            (m_phase == PH_RUN), (m_phase == PH_FAULT), r, l};
  endfunction

  task automatic model_step(input bit r, input bit rs, input bit l);
    bit seen;
    if (r) begin
      m_phase = PH_RST; m_n = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    seen = m_s2;  // lock as the sequencer sees it: two edges old
    m_s2 = m_s1;
    m_s1 = l;
    if (rs) begin
      m_phase = PH_RST; m_n = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      PH_RST: begin
        m_n++;
        if (m_n == RST_CYCLES) begin m_phase = PH_WAIT; m_n = 0; end
      end
      PH_WAIT: begin
        if (seen) begin
          m_phase = PH_STABLE; m_n = 0;
        end else if (m_n + 1 == LOCK_TIMEOUT) begin
          if (m_retry == MAX_RETRY) m_phase = PH_FAULT;
          else begin m_retry++; m_phase = PH_RST; m_n = 0; end
        end else m_n++;
      end
      PH_STABLE: begin
        if (!seen) begin
          m_phase = PH_WAIT; m_n = 0;
        end else if (m_n + 1 == STABLE_CYCLES) begin
          m_phase = PH_RUN; m_n = 0;
        end else m_n++;
      end
      PH_RUN: begin
        if (!seen) begin
          if (m_loss < 255) m_loss++;
          m_retry = 0; m_phase = PH_RST; m_n = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit r, input bit rs, input bit l);
    logic [13:0] v;
    rst             = r;
    pll_if.restart  = rs;
    pll_if.pll_lock = l;
    @(posedge clk_tb);
    cyc++;
    model_step(r, rs, l);
    v = m_vec();
    if (m_first || v != m_prev) begin
      exp_q.push_back('{cyc, v});
      m_prev  = v;
      m_first = 0;
    end
    started = 1;
    @(negedge clk_tb);
  endtask

  // monitor: every change of the DUT outputs is one transaction
  initial begin
    logic [13:0] dv;
    logic [13:0] dut_prev;
    bit          mon_first;
    exp_t        e;
    mon_first = 1;
    dut_prev  = '0;
    forever begin
      @(negedge clk_tb);
      if (started) begin
        dv = {pll_if.pll_rst, pll_if.hdmi_rst, pll_if.locked_ok, pll_if.fault,
              pll_if.retry_cnt, pll_if.lock_loss_cnt};
        if (mon_first || dv !== dut_prev) begin
          mon_first = 0;
          dut_prev  = dv;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL txn_unexpected cyc=%0d got=%b required=no change", cyc, dv);
          end else begin
            e = exp_q.pop_front();
            if (e.vec !== dv || e.cyc != cyc) begin
              failures++;
              $display("FAIL txn cyc=%0d got=%b required=%b at cyc %0d", cyc, dv, e.vec, e.cyc);
            end else begin
              $display("txn cyc=%0d pll_rst=%b hdmi_rst=%b locked_ok=%b fault=%b retry=%0d loss=%0d",
                       cyc, dv[13], dv[12], dv[11], dv[10], dv[9:8], dv[7:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    pll_if.restart  = 1'b0;
    pll_if.pll_lock = 1'b0;

    repeat (2) cycle(1, 0, 0);

    // bring-up: lock appears after pll_rst has fallen, then stays
    repeat (RST_CYCLES + 9) cycle(0, 0, 0);
    repeat (20) cycle(0, 0, 1);

    // no lock at all: three reset attempts then fault
    cycle(0, 1, 0);
    repeat (3 * (RST_CYCLES + LOCK_TIMEOUT) + 10) cycle(0, 0, 0);

    // restart out of fault, then again part way through the pll_rst pulse
    cycle(0, 1, 0);
    repeat ($urandom_range(1, 2)) cycle(0, 0, 0);
    cycle(0, 1, 0);
    repeat (RST_CYCLES + 2) cycle(0, 0, 0);

    // lock glitch while counting stability
    repeat (6 + $urandom_range(0, 3)) cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);
    repeat (20) cycle(0, 0, 1);

    // repeated lock loss in RUN drives the loss counter into saturation
    for (int i = 0; i < 260; i++) begin
      repeat ($urandom_range(1, 4)) cycle(0, 0, 0);
      repeat (18 + $urandom_range(0, 4)) cycle(0, 0, 1);
    end
    checks++;
    if (pll_if.lock_loss_cnt !== 8'd255 || pll_if.locked_ok !== 1'b1) begin
      failures++;
      $display("FAIL loss_saturate got=%0d locked_ok=%b required=255 locked_ok=1",
               pll_if.lock_loss_cnt, pll_if.locked_ok);
    end

    // synchronous reset while running
    cycle(1, 0, 1);
    repeat (20) cycle(0, 0, 1);

    // random lock flicker and occasional restart
    lock_v = 1;
    repeat (800) begin
      if ($urandom_range(0, 99) < 6) lock_v = ~lock_v;
      cycle(0, ($urandom_range(0, 199) == 0), lock_v);
    end
    repeat (5) cycle(0, 0, lock_v);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL txn_missing got=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
